// File: rtl/ram_seq_pkg.sv
// Shared constants for the RAM request sequencer: FSM encoding, op codes and default widths.
// Used by ram_request_sequencer and ram_seq_grouper.
package ram_seq_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ADDR_W_DEF = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/ram_seq_grouper.sv
// Combinational group selection: decides which holding slots go to the RAM together in the next
// cycle, and with which op.
module ram_seq_grouper
    import ram_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [1:0]        i_full,
    input  logic              i_op0,
    input  logic              i_op1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic              i_rr,
    output logic              o_issue0,
    output logic              o_issue1,
    output logic              o_op
);

    // Pair same-op requests unless they are writes to one address; same-address writes go slot0 first.
    always_comb begin
        o_issue0 = 1'b0;
        o_issue1 = 1'b0;
        o_op     = OP_RD;
        if (i_full == 2'b11) begin
            if ((i_op0 == i_op1) && ((i_addr0 != i_addr1) || (i_op0 == OP_RD))) begin
                o_issue0 = 1'b1;
                o_issue1 = 1'b1;
                o_op     = i_op0;
            end else if ((i_op0 == OP_WR) && (i_op1 == OP_WR)) begin
                o_issue0 = 1'b1;
                o_op     = i_op0;
            end else if (i_rr) begin
                o_issue1 = 1'b1;
                o_op     = i_op1;
            end else begin
                o_issue0 = 1'b1;
                o_op     = i_op0;
            end
        end else if (i_full[0]) begin
            o_issue0 = 1'b1;
            o_op     = i_op0;
        end else if (i_full[1]) begin
            o_issue1 = 1'b1;
            o_op     = i_op1;
        end else begin
            o_op     = OP_RD;
        end
    end

endmodule

// File: rtl/ram_request_sequencer.sv
// Two-client request sequencer in front of the 8-entry dual-port RAM controller.
// Optional feature macro: RAM_SEQ_WRITE_ACK_EN (writes also return a response carrying the written data).
module ram_request_sequencer
    import ram_seq_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic              i_req0_wr,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [WIDTH-1:0]  i_req0_wdata,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic              i_req1_wr,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [WIDTH-1:0]  i_req1_wdata,
    output logic              o_rsp0_valid,
    input  logic              i_rsp0_ready,
    output logic [WIDTH-1:0]  o_rsp0_data,
    output logic              o_rsp1_valid,
    input  logic              i_rsp1_ready,
    output logic [WIDTH-1:0]  o_rsp1_data,
    output logic              o_ram_wr,
    output logic [ADDR_W-1:0] o_ram_addr0,
    output logic [ADDR_W-1:0] o_ram_addr1,
    output logic [WIDTH-1:0]  o_ram_w_in0,
    output logic [WIDTH-1:0]  o_ram_w_in1,
    input  logic [WIDTH-1:0]  i_ram_r_out0,
    input  logic [WIDTH-1:0]  i_ram_r_out1
);

    logic [1:0]              r_state;
    logic [1:0]              r_full;
    logic [1:0]              r_op;
    logic [1:0][ADDR_W-1:0]  r_addr;
    logic [1:0][WIDTH-1:0]   r_wdata;
    logic [1:0]              r_iss;
    logic                    r_grp_op;
    logic                    r_rr;
    logic [1:0]              r_rsp_valid;
    logic [WIDTH-1:0]        r_rsp_data0;
    logic [WIDTH-1:0]        r_rsp_data1;
    logic                    r_ram_wr;
    logic [ADDR_W-1:0]       r_ram_addr0;
    logic [ADDR_W-1:0]       r_ram_addr1;
    logic [WIDTH-1:0]        r_ram_w_in0;
    logic [WIDTH-1:0]        r_ram_w_in1;

    logic [1:0]              w_accept;
    logic [1:0]              w_release;
    logic [1:0]              w_rsp_take;
    logic [1:0]              w_rsp_left;
    logic                    w_iss0;
    logic                    w_iss1;
    logic                    w_op;

    assign w_accept   = {i_req1_valid, i_req0_valid} & ~r_full;
    assign w_rsp_take = r_rsp_valid & {i_rsp1_ready, i_rsp0_ready};
    assign w_rsp_left = r_rsp_valid & ~w_rsp_take;

    assign o_req0_ready = ~r_full[0];
    assign o_req1_ready = ~r_full[1];
    assign o_rsp0_valid = r_rsp_valid[0];
    assign o_rsp1_valid = r_rsp_valid[1];
    assign o_rsp0_data  = r_rsp_data0;
    assign o_rsp1_data  = r_rsp_data1;
    assign o_ram_wr     = r_ram_wr;
    assign o_ram_addr0  = r_ram_addr0;
    assign o_ram_addr1  = r_ram_addr1;
    assign o_ram_w_in0  = r_ram_w_in0;
    assign o_ram_w_in1  = r_ram_w_in1;

    ram_seq_grouper #(.ADDR_W(ADDR_W)) u_grouper (
        .i_full   (r_full),
        .i_op0    (r_op[0]),
        .i_op1    (r_op[1]),
        .i_addr0  (r_addr[0]),
        .i_addr1  (r_addr[1]),
        .i_rr     (r_rr),
        .o_issue0 (w_iss0),
        .o_issue1 (w_iss1),
        .o_op     (w_op)
    );

    // Slot release points: writes free their slot at the RAM edge unless they must be acknowledged.
    always_comb begin
        w_release = 2'b00;
        case (r_state)
            ST_ISSUE: begin
`ifdef RAM_SEQ_WRITE_ACK_EN
                w_release = 2'b00;
`else
                if (r_grp_op == OP_WR) begin
                    w_release = r_iss;
                end else begin
                    w_release = 2'b00;
                end
`endif
            end
            ST_RESP: w_release = w_rsp_take;
            default: w_release = 2'b00;
        endcase
    end

    // Holding slots: refilled only while empty, cleared on release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full  <= 2'b00;
            r_op    <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_release[k]) begin
                    r_full[k] <= 1'b0;
                end else if (w_accept[k]) begin
                    r_full[k]  <= 1'b1;
                    r_op[k]    <= (k == 0) ? i_req0_wr    : i_req1_wr;
                    r_addr[k]  <= (k == 0) ? i_req0_addr  : i_req1_addr;
                    r_wdata[k] <= (k == 0) ? i_req0_wdata : i_req1_wdata;
                end
            end
        end
    end

    // Sequencing FSM and registered RAM-side / response-side outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_iss       <= 2'b00;
            r_grp_op    <= OP_RD;
            r_rr        <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_data0 <= '0;
            r_rsp_data1 <= '0;
            r_ram_wr    <= 1'b0;
            r_ram_addr0 <= '0;
            r_ram_addr1 <= '0;
            r_ram_w_in0 <= '0;
            r_ram_w_in1 <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|r_full) begin
                        r_iss    <= {w_iss1, w_iss0};
                        r_grp_op <= w_op;
                        r_ram_wr <= w_op;
                        r_state  <= ST_ISSUE;
                        if (w_iss0 ^ w_iss1) begin
                            r_rr <= ~r_rr;
                        end
                        // Single writes drive both ports identically; single reads park the idle port at 0.
                        if (w_iss0 && w_iss1) begin
                            r_ram_addr0 <= r_addr[0];
                            r_ram_addr1 <= r_addr[1];
                            r_ram_w_in0 <= (w_op == OP_WR) ? r_wdata[0] : '0;
                            r_ram_w_in1 <= (w_op == OP_WR) ? r_wdata[1] : '0;
                        end else if (w_iss0) begin
                            r_ram_addr0 <= r_addr[0];
                            r_ram_addr1 <= (w_op == OP_WR) ? r_addr[0] : '0;
                            r_ram_w_in0 <= (w_op == OP_WR) ? r_wdata[0] : '0;
                            r_ram_w_in1 <= (w_op == OP_WR) ? r_wdata[0] : '0;
                        end else begin
                            r_ram_addr0 <= (w_op == OP_WR) ? r_addr[1] : '0;
                            r_ram_addr1 <= r_addr[1];
                            r_ram_w_in0 <= (w_op == OP_WR) ? r_wdata[1] : '0;
                            r_ram_w_in1 <= (w_op == OP_WR) ? r_wdata[1] : '0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_ram_wr <= 1'b0;
                    if (r_grp_op == OP_WR) begin
                        r_ram_addr0 <= '0;
                        r_ram_addr1 <= '0;
                        r_ram_w_in0 <= '0;
                        r_ram_w_in1 <= '0;
`ifdef RAM_SEQ_WRITE_ACK_EN
                        r_rsp_valid <= r_iss;
                        if (r_iss[0]) begin
                            r_rsp_data0 <= r_wdata[0];
                        end
                        if (r_iss[1]) begin
                            r_rsp_data1 <= r_wdata[1];
                        end
                        r_state <= ST_RESP;
`else
                        r_state <= ST_IDLE;
`endif
                    end else begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_ram_addr0 <= '0;
                    r_ram_addr1 <= '0;
                    if (r_iss[0]) begin
                        r_rsp_data0 <= i_ram_r_out0;
                    end
                    if (r_iss[1]) begin
                        r_rsp_data1 <= i_ram_r_out1;
                    end
                    r_rsp_valid <= r_iss;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    r_rsp_valid <= w_rsp_left;
                    if (w_rsp_left == 2'b00) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_request_sequencer.sv
// Directed self-checking bench for ram_request_sequencer with a small registered dual-port RAM model.
// Honours RAM_SEQ_WRITE_ACK_EN when the design is built with it.
module tb_ram_request_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic        req0_wr = 1'b0, req1_wr = 1'b0;
    logic [2:0]  req0_addr = 3'd0, req1_addr = 3'd0;
    logic [31:0] req0_wdata = 32'h0, req1_wdata = 32'h0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp0_data, rsp1_data;
    logic        ram_wr;
    logic [2:0]  ram_addr0, ram_addr1;
    logic [31:0] ram_w_in0, ram_w_in1;
    logic [31:0] ram_r_out0 = 32'h0, ram_r_out1 = 32'h0;
    logic [31:0] mem [8] = '{default: 32'h0};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_request_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (req0_valid),
        .o_req0_ready (req0_ready),
        .i_req0_wr    (req0_wr),
        .i_req0_addr  (req0_addr),
        .i_req0_wdata (req0_wdata),
        .i_req1_valid (req1_valid),
        .o_req1_ready (req1_ready),
        .i_req1_wr    (req1_wr),
        .i_req1_addr  (req1_addr),
        .i_req1_wdata (req1_wdata),
        .o_rsp0_valid (rsp0_valid),
        .i_rsp0_ready (rsp0_ready),
        .o_rsp0_data  (rsp0_data),
        .o_rsp1_valid (rsp1_valid),
        .i_rsp1_ready (rsp1_ready),
        .o_rsp1_data  (rsp1_data),
        .o_ram_wr     (ram_wr),
        .o_ram_addr0  (ram_addr0),
        .o_ram_addr1  (ram_addr1),
        .o_ram_w_in0  (ram_w_in0),
        .o_ram_w_in1  (ram_w_in1),
        .i_ram_r_out0 (ram_r_out0),
        .i_ram_r_out1 (ram_r_out1)
    );

    // Controller stand-in: writes both ports when ram_wr, otherwise registers both read ports.
    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr0] <= ram_w_in0;
            mem[ram_addr1] <= ram_w_in1;
        end else begin
            ram_r_out0 <= mem[ram_addr0];
            ram_r_out1 <= mem[ram_addr1];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_reqs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_ready0", {31'h0, req0_ready}, 32'h1);
        chk("rst_ready1", {31'h0, req1_ready}, 32'h1);
        chk("rst_rsp0_valid", {31'h0, rsp0_valid}, 32'h0);
        chk("rst_rsp1_valid", {31'h0, rsp1_valid}, 32'h0);
        chk("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
        chk("rst_rsp0_data", rsp0_data, 32'h0);
        chk("rst_ram_w_in0", ram_w_in0, 32'h0);
        rst = 1'b0;

        // 1: reset in the middle of a write ISSUE
        req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 3'd7; req0_wdata = 32'h0000_0077;
        step();
        idle_reqs();
        chk("t1_ready0_full", {31'h0, req0_ready}, 32'h0);
        step();
        chk("t1_issue_wr", {31'h0, ram_wr}, 32'h1);
        chk("t1_issue_addr1", {29'h0, ram_addr1}, 32'h7);
        rst = 1'b1;
        #1;
        chk("t1_rst_ram_wr", {31'h0, ram_wr}, 32'h0);
        chk("t1_rst_ready0", {31'h0, req0_ready}, 32'h1);
        chk("t1_rst_rsp0_valid", {31'h0, rsp0_valid}, 32'h0);
        step();
        rst = 1'b0;

        // 2: paired writes, then paired reads
        req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 3'd2; req0_wdata = 32'hA5A5_A5A5;
        req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 3'd5; req1_wdata = 32'h5A5A_5A5A;
        step();
        idle_reqs();
        chk("t2_ready0", {31'h0, req0_ready}, 32'h0);
        chk("t2_ready1", {31'h0, req1_ready}, 32'h0);
        step();
        chk("t2_wr", {31'h0, ram_wr}, 32'h1);
        chk("t2_addr0", {29'h0, ram_addr0}, 32'h2);
        chk("t2_addr1", {29'h0, ram_addr1}, 32'h5);
        chk("t2_w_in0", ram_w_in0, 32'hA5A5_A5A5);
        chk("t2_w_in1", ram_w_in1, 32'h5A5A_5A5A);
        step();
        chk("t2_wr_done", {31'h0, ram_wr}, 32'h0);
        chk("t2_rel0", {31'h0, req0_ready}, 32'h1);
        chk("t2_rel1", {31'h0, req1_ready}, 32'h1);
        chk("t2_no_rsp", {31'h0, rsp0_valid}, 32'h0);
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 3'd2;
        req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 3'd5;
        step();
        idle_reqs();
        step();
        chk("t2_rd_issue_wr", {31'h0, ram_wr}, 32'h0);
        chk("t2_rd_addr0", {29'h0, ram_addr0}, 32'h2);
        chk("t2_rd_addr1", {29'h0, ram_addr1}, 32'h5);
        step();
        chk("t2_cap_addr0", {29'h0, ram_addr0}, 32'h2);
        chk("t2_cap_valid", {31'h0, rsp0_valid}, 32'h0);
        step();
        chk("t2_rsp0_valid", {31'h0, rsp0_valid}, 32'h1);
        chk("t2_rsp1_valid", {31'h0, rsp1_valid}, 32'h1);
        chk("t2_rsp0_data", rsp0_data, 32'hA5A5_A5A5);
        chk("t2_rsp1_data", rsp1_data, 32'h5A5A_5A5A);
        step();
        chk("t2_rsp_taken", {30'h0, rsp1_valid, rsp0_valid}, 32'h0);
        chk("t2_ready_back", {30'h0, req1_ready, req0_ready}, 32'h3);

        // 3: mixed ops, read of addr1 first with rr=0
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 3'd1;
        req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 3'd1; req1_wdata = 32'h0000_0011;
        step();
        idle_reqs();
        step();
        chk("t3_rd_first", {31'h0, ram_wr}, 32'h0);
        chk("t3_rd_addr0", {29'h0, ram_addr0}, 32'h1);
        chk("t3_idle_port", {29'h0, ram_addr1}, 32'h0);
        step();
        step();
        chk("t3_rsp0_valid", {31'h0, rsp0_valid}, 32'h1);
        chk("t3_rsp0_old", rsp0_data, 32'h0);
        chk("t3_rsp1_quiet", {31'h0, rsp1_valid}, 32'h0);
        chk("t3_slot1_held", {31'h0, req1_ready}, 32'h0);
        step();
        step();
        chk("t3_wr_second", {31'h0, ram_wr}, 32'h1);
        chk("t3_wr_addr0", {29'h0, ram_addr0}, 32'h1);
        chk("t3_wr_addr1", {29'h0, ram_addr1}, 32'h1);
        chk("t3_wr_w_in1", ram_w_in1, 32'h0000_0011);
        step();
        chk("t3_rel1", {31'h0, req1_ready}, 32'h1);
        chk("t3_rr", {31'h0, dut.r_rr}, 32'h0);

        // 4: same-address write collision, slot0 then slot1
        req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 3'd3; req0_wdata = 32'h0000_0001;
        req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 3'd3; req1_wdata = 32'h0000_0002;
        step();
        idle_reqs();
        step();
        chk("t4_first_wr", {31'h0, ram_wr}, 32'h1);
        chk("t4_first_data", ram_w_in0, 32'h0000_0001);
        chk("t4_first_data1", ram_w_in1, 32'h0000_0001);
        step();
        chk("t4_gap_wr", {31'h0, ram_wr}, 32'h0);
        chk("t4_gap_ready", {30'h0, req1_ready, req0_ready}, 32'h1);
        step();
        chk("t4_second_wr", {31'h0, ram_wr}, 32'h1);
        chk("t4_second_addr", {29'h0, ram_addr0}, 32'h3);
        chk("t4_second_data", ram_w_in0, 32'h0000_0002);
        step();

        // 4/5: read back addr3 under response backpressure
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 3'd3;
        rsp0_ready = 1'b0;
        step();
        idle_reqs();
        step();
        step();
        step();
        chk("t4_rd_valid", {31'h0, rsp0_valid}, 32'h1);
        chk("t4_rd_data", rsp0_data, 32'h0000_0002);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold_valid", {31'h0, rsp0_valid}, 32'h1);
            chk("t5_hold_data", rsp0_data, 32'h0000_0002);
            chk("t5_hold_ready0", {31'h0, req0_ready}, 32'h0);
            chk("t5_hold_ram_wr", {31'h0, ram_wr}, 32'h0);
        end
        rsp0_ready = 1'b1;
        step();
        chk("t5_taken", {31'h0, rsp0_valid}, 32'h0);
        chk("t5_ready0", {31'h0, req0_ready}, 32'h1);
        chk("t5_idle", {30'h0, dut.r_state}, 32'h0);

        // 6: single write, acknowledged only when the ack feature is built in
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 3'd4; req0_wdata = 32'hDEAD_BEEF;
        step();
        idle_reqs();
        step();
        chk("t6_wr", {31'h0, ram_wr}, 32'h1);
        chk("t6_both_addr", {26'h0, ram_addr1, ram_addr0}, 32'h24);
        chk("t6_w_in1", ram_w_in1, 32'hDEAD_BEEF);
        for (int i = 0; i < 2; i++) begin
            step();
`ifdef RAM_SEQ_WRITE_ACK_EN
            chk("t6_ack_valid", {31'h0, rsp0_valid}, 32'h1);
            chk("t6_ack_data", rsp0_data, 32'hDEAD_BEEF);
            chk("t6_ack_ready0", {31'h0, req0_ready}, 32'h0);
`else
            chk("t6_no_ack", {31'h0, rsp0_valid}, 32'h0);
            chk("t6_ready0", {31'h0, req0_ready}, 32'h1);
`endif
        end
        rsp0_ready = 1'b1;
        step();
        chk("t6_end_valid", {31'h0, rsp0_valid}, 32'h0);
        chk("t6_end_ready0", {31'h0, req0_ready}, 32'h1);
        chk("t6_mem4", mem[4], 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
